mat_key_responder: RTL and testbench

Synthesizable 4x4 matrix-keypad emulator: the responder end of the row-scan/column-sense keypad interface used by the game top level. It answers the scanner's active-low row drive with active-low column returns, replaying queued key-press commands with programmable hold time, contact bounce on press and release, and an inter-press gap. It is used in simulation benches and as a self-test source that feeds the keypad scanner without a physical keypad.

---
 rtl/mat_key_responder.sv | 204 ++++++++++++++++++++
 tb/tb_mat_key_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_key_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mat_key_responder
//  Description : 4x4 matrix-keypad emulator. Answers an active-low row scan
//                with active-low column returns while replaying queued key
//                presses. Each press has a bounce window, a stable hold, a
//                release bounce window and an inter-press gap.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          system clock
//    rst          synchronous active-high reset
//    row[3:0]     scanner row drive, active-low
//    col[3:0]     column return, active-low, registered
//    cmd_valid    command offered
//    cmd_ready    command queue not full
//    cmd_key      key index k = 4*r + c
//    cmd_hold     stable-press length in clk cycles (0 behaves as 1)
//    busy         press sequence active or queue non-empty
//    done         one-cycle pulse in the last gap cycle of a command
//    pressed_vec  one-hot of the key currently closed, else 0
// ============================================================================
module mat_key_responder #(
   parameter int FIFO_DEPTH    = 4,
   parameter int BOUNCE_CYCLES = 2000,
   parameter int BOUNCE_PERIOD = 250,
   parameter int GAP_CYCLES    = 10000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_key,
   input  logic [15:0] cmd_hold,
   output logic        busy,
   output logic        done,
   output logic [15:0] pressed_vec
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int MAX_BG  = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
   localparam int CNT_MAX = (MAX_BG > 65535) ? MAX_BG : 65535;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Terminal counts: a phase ends when the counter reaches its last value
   localparam logic [CNT_W-1:0] BON_LAST = CNT_W'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PER_C    = CNT_W'((BOUNCE_PERIOD < 1) ? 1 : BOUNCE_PERIOD);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      BOUNCE_ON  = 3'd1,
      HOLD       = 3'd2,
      BOUNCE_OFF = 3'd3,
      GAP        = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Command queue
   // ------------------------------------------------------------------
   logic [3:0]       key_mem  [FIFO_DEPTH];
   logic [15:0]      hold_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   occ;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign full      = (occ == OCC_FULL);
   assign empty     = (occ == '0);
   assign cmd_ready = !full;
   // A push while full is refused because cmd_ready is already low
   assign push      = cmd_valid & cmd_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         key_mem[wr_ptr]  <= cmd_key;
         hold_mem[wr_ptr] <= cmd_hold;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Press sequencer
   // ------------------------------------------------------------------
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       key_reg;
   logic [15:0]      hold_reg;
   logic [CNT_W-1:0] hold_last;
   logic             bounce_odd;
   logic             closed;
   logic [3:0]       col_nx;

   assign hold_last  = (hold_reg == 16'd0) ? '0 : CNT_W'(hold_reg - 16'd1);
   // Odd bounce slot: counter divided into BOUNCE_PERIOD-long slots
   assign bounce_odd = ((cnt / PER_C) & CNT_ONE) != '0;
   assign busy       = (state != IDLE) | !empty;

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      done     = 1'b0;
      closed   = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = (BOUNCE_CYCLES == 0) ? HOLD : BOUNCE_ON;
            end
         end
         BOUNCE_ON: begin
            // Contact closes in the first slot, then alternates
            closed = !bounce_odd;
            if (cnt == BON_LAST) state_nx = HOLD;
         end
         HOLD: begin
            closed = 1'b1;
            if (cnt == hold_last) state_nx = (BOUNCE_CYCLES == 0) ? GAP : BOUNCE_OFF;
         end
         BOUNCE_OFF: begin
            // Contact opens in the first slot, then alternates
            closed = bounce_odd;
            if (cnt == BON_LAST) state_nx = GAP;
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nx = IDLE;
               done     = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         key_reg  <= '0;
         hold_reg <= '0;
      end else begin
         state <= state_nx;
         // Phase counter restarts on every state change
         cnt   <= (state_nx != state) ? '0 : cnt + CNT_ONE;
         if (pop) begin
            key_reg  <= key_mem[rd_ptr];
            hold_reg <= hold_mem[rd_ptr];
         end
      end
   end

   // ------------------------------------------------------------------
   // Contact matrix: a closed key pulls its column low when its row is low
   // ------------------------------------------------------------------
   always_comb begin
      col_nx = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!row[r] && pressed_vec[4*r + c]) col_nx[c] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pressed_vec <= 16'h0000;
         col         <= 4'hF;
      end else begin
         pressed_vec <= closed ? (16'h0001 << key_reg) : 16'h0000;
         col         <= col_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mat_key_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mat_key_responder
//  Description : Scoreboard bench for mat_key_responder. Accepted commands are
//                queued with the driver; a monitor expands each into its
//                per-cycle contact trace and checks pressed_vec, col, done,
//                busy and cmd_ready every cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports       : none (top-level bench)
// ============================================================================
module tb_mat_key_responder;

   localparam int B = 8;
   localparam int P = 2;
   localparam int G = 4;

   typedef struct {
      logic [3:0]  key;
      logic [15:0] hold;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row = 4'b1110;
   logic        cmd_valid = 1'b0;
   logic [3:0]  cmd_key = 4'h0;
   logic [15:0] cmd_hold = 16'h0;
   logic [3:0]  col;
   logic        cmd_ready;
   logic        busy;
   logic        done;
   logic [15:0] pressed_vec;

   logic        valid0 = 1'b0;
   logic [3:0]  key0 = 4'h0;
   logic [15:0] hold0 = 16'h0;
   logic [3:0]  col0;
   logic        ready0;
   logic        busy0;
   logic        done0;
   logic [15:0] pv0;

   cmd_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   bit   rand_row = 1'b0;

   always #5 clk = ~clk;

   mat_key_responder #(
      .FIFO_DEPTH(4), .BOUNCE_CYCLES(B), .BOUNCE_PERIOD(P), .GAP_CYCLES(G)
   ) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
      .busy(busy), .done(done), .pressed_vec(pressed_vec)
   );

   mat_key_responder #(
      .FIFO_DEPTH(4), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .GAP_CYCLES(0)
   ) dut0 (
      .clk(clk), .rst(rst), .row(row), .col(col0),
      .cmd_valid(valid0), .cmd_ready(ready0), .cmd_key(key0), .cmd_hold(hold0),
      .busy(busy0), .done(done0), .pressed_vec(pv0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_row) row = 4'($urandom);
   endtask

   task automatic push(input logic [3:0] k, input logic [15:0] h, output int waited);
      cmd_t c;
      waited    = 0;
      cmd_valid = 1'b1;
      cmd_key   = k;
      cmd_hold  = h;
      while (!cmd_ready && waited < 3000) begin
         tick();
         waited++;
      end
      if (!cmd_ready) begin
         check("push_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk);
         c.key  = k;
         c.hold = h;
         exp_q.push_back(c);
         #1;
         cmd_valid = 1'b0;
         // Scramble the command inputs: only the pushed values may matter
         cmd_key   = 4'($urandom);
         cmd_hold  = 16'($urandom);
         if (rand_row) row = 4'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
      tick();
      tick();
   endtask

   task automatic wait_pressed();
      int n = 0;
      while (pressed_vec == 16'h0 && n < 200) begin
         tick();
         n++;
      end
      if (pressed_vec == 16'h0) check("press_timeout", 32'(pressed_vec != 16'h0), 32'd1);
   endtask

   // Short sequence on the bounce-free instance: count closed cycles and done pulses
   task automatic run0(input logic [3:0] k, input logic [15:0] h, input int n_closed);
      int nc = 0;
      int nd = 0;
      check("b0_ready", 32'(ready0), 32'd1);
      valid0 = 1'b1;
      key0   = k;
      hold0  = h;
      tick();
      valid0 = 1'b0;
      key0   = ~k;
      repeat (30) begin
         @(negedge clk);
         if (pv0 != 16'h0) begin
            nc++;
            check("b0_pv", 32'(pv0), 32'(16'h0001 << k));
         end
         if (done0) nd++;
      end
      check("b0_closed_cycles", nc, n_closed);
      check("b0_done_pulses", nd, 1);
      check("b0_busy_end", 32'(busy0), 32'd0);
      tick();
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   initial begin : monitor
      bit          rst_prev;
      bit          in_tr;
      int          j;
      int          len;
      int          hh;
      int          gg;
      logic [15:0] tr[$];
      logic [15:0] onehot;
      logic [3:0]  prow;
      logic [15:0] ppv;
      logic [15:0] epv;
      logic [3:0]  ecol;
      logic        edone;
      logic        ebusy;
      cmd_t        c;
      rst_prev = 1'b1;
      in_tr    = 1'b0;
      j        = 0;
      len      = 0;
      prow     = 4'hF;
      ppv      = 16'h0;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            check("rst_pressed", 32'(pressed_vec), 32'h0);
            check("rst_col", 32'(col), 32'hF);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_ready", 32'(cmd_ready), 32'd1);
            exp_q.delete();
            in_tr = 1'b0;
            ppv   = 16'h0;
         end else begin
            // Column model: the one closed key pulls its column low if its row is driven
            ecol = 4'hF;
            for (int k = 0; k < 16; k++)
               if (ppv[k] && !prow[k / 4]) ecol[k % 4] = 1'b0;
            if (!in_tr && pressed_vec != 16'h0 && exp_q.size() > 0) begin
               c      = exp_q.pop_front();
               onehot = 16'h0001 << c.key;
               hh     = (c.hold == 16'd0) ? 1 : int'(c.hold);
               gg     = (G == 0) ? 1 : G;
               tr.delete();
               for (int i = 0; i < B; i++)  tr.push_back(((i / P) % 2 == 0) ? onehot : 16'h0);
               for (int i = 0; i < hh; i++) tr.push_back(onehot);
               for (int i = 0; i < B; i++)  tr.push_back(((i / P) % 2 == 1) ? onehot : 16'h0);
               for (int i = 0; i < gg; i++) tr.push_back(16'h0);
               len   = tr.size();
               in_tr = 1'b1;
               j     = 0;
            end
            if (in_tr) begin
               epv   = tr[j];
               edone = (j == len - 2);
               ebusy = (j <= len - 2) || (exp_q.size() > 0);
            end else begin
               epv   = 16'h0;
               edone = 1'b0;
               ebusy = (exp_q.size() > 0);
            end
            check("pressed_vec", 32'(pressed_vec), 32'(epv));
            check("col", 32'(col), 32'(ecol));
            check("done", 32'(done), 32'(edone));
            check("busy", 32'(busy), 32'(ebusy));
            if (exp_q.size() == 0) check("ready_empty", 32'(cmd_ready), 32'd1);
            if (in_tr) begin
               j++;
               if (j == len) in_tr = 1'b0;
            end
            ppv = epv;
         end
         prow     = row;
         rst_prev = rst;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin : driver
      int w;
      // Reset then idle with a row driven low
      row = 4'b1110;
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();

      // Single press of key 10 on its own row
      row = 4'b1011;
      push(4'd10, 16'd5, w);
      wait_idle();

      // Same key, non-matching row
      row = 4'b1110;
      push(4'd10, 16'd5, w);
      wait_idle();

      // All rows low, key 15
      row = 4'b0000;
      push(4'd15, 16'd3, w);
      wait_idle();

      // Queue full while the first command is in HOLD
      row = 4'b0000;
      push(4'd3, 16'd20, w);
      wait_pressed();
      repeat (8) tick();
      push(4'd4, 16'd2, w);
      push(4'd9, 16'd0, w);
      push(4'd14, 16'd3, w);
      push(4'd1, 16'd1, w);
      check("ready_when_full", 32'(cmd_ready), 32'd0);
      push(4'd12, 16'd4, w);
      check("fifth_push_waited", 32'(w > 5), 32'd1);
      wait_idle();

      // Randomized commands, rows and spacing
      rand_row = 1'b1;
      repeat (12) begin
         push(4'($urandom), 16'($urandom_range(0, 12)), w);
         repeat ($urandom_range(0, 40)) tick();
      end
      wait_idle();
      rand_row = 1'b0;

      // Reset during HOLD with commands still queued
      row = 4'b0000;
      push(4'd5, 16'd30, w);
      push(4'd6, 16'd4, w);
      push(4'd7, 16'd4, w);
      wait_pressed();
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (80) tick();

      // Bounce-free instance: hold 0 closes exactly one cycle
      run0(4'd9, 16'd0, 1);
      run0(4'd2, 16'd3, 3);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
